fifo_push_rr_arbiter: RTL and testbench
=======================================

Name: fifo_push_rr_arbiter

Overview:
Shares the write port of one FIFO (push/write_data/full/pop interface) between n_req producers. Arbitration is round-robin, with optional burst locking so one producer can write up to max_burst consecutive words. The block sits directly in front of the FIFO. It drives push/write_data and returns a per-requester ready.

Parameters:
width, 8, data word width (matches the FIFO width)
n_req, 3, number of requesters (2..8)
max_burst, 2, max consecutive accepted words per grant (1 = pure round-robin, no lock)
allow_push_when_full_with_pop, 1, 1 = a push is legal when full is high and pop is high in the same cycle

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  n_req  request i has a word available
req_data  in  n_req*width  word of request i at bits [i*width +: width]
req_ready  out  n_req  one-hot or zero; word of request i accepted this cycle
push  out  1  FIFO push
write_data  out  width  FIFO write data
full  in  1  FIFO full
pop  in  1  FIFO pop (same cycle)
grant_valid  out  1  a requester is selected this cycle (may be stalled)
grant_id  out  max(1,$clog2(n_req))  selected requester index

Behaviour:
- One clock (clk). Async active-high reset (rst) → state IDLE, ptr=0, owner=0, cnt=0.
- accept = ~full | (allow_push_when_full_with_pop & full & pop).
- Outputs are combinational from state plus inputs. There is no added latency: a word is written to the FIFO in the cycle its req_ready is high.
- IDLE:
  - grant = first i with req_valid[i], searching ptr, ptr+1, …, n_req-1, 0, …, ptr-1 (wraps).
  - If no req_valid is high: grant_valid=0, push=0, req_ready=0.
  - If a grant exists: grant_valid=1, grant_id=i, write_data=req_data[i], push=accept, req_ready[i]=accept.
  - On an accepted transfer with max_burst==1: ptr ← i+1 (mod n_req).
  - On an accepted transfer with max_burst>1: → LOCKED, owner ← i, cnt ← 1.
  - Not accepted (full): no state change. Arbitration is re-evaluated next cycle from the same ptr.
- LOCKED:
  - Only the owner is considered.
  - If req_valid[owner]=1: grant_valid=1, grant_id=owner, push=accept.
    - If accepted: cnt ← cnt+1.
    - If accepted and cnt+1==max_burst: → IDLE, ptr ← owner+1.
    - If stalled by full: remain LOCKED, cnt unchanged.
  - If req_valid[owner]=0: grant_valid=0, push=0 this cycle (one bubble), → IDLE, ptr ← owner+1.
- Invariants:
  - At most one req_ready bit high per cycle.
  - push=1 only when accept=1.
  - push=0 whenever full=1 and (pop=0 or allow_push_when_full_with_pop=0).
- Requester rules (verified by assertions):
  - A requester holds req_valid and req_data stable until its req_ready is high.
  - The arbiter does not depend on this for correctness.
- Reset asserted mid-burst: immediate return to IDLE, ptr=0. push and req_ready go 0 while rst is high.
- ptr and owner wrap modulo n_req. cnt width = $clog2(max_burst+1).

Test Plan:
(n_req=3, width=8, max_burst=2 unless noted)
- Single requester: req_valid=3'b010, data 8'h11,8'h22,8'h33, full=0.
  - push on 3 consecutive cycles, grant_id=1 each time.
  - A lock bubble appears only if valid drops, so with valid held: 11,22 (burst ends, ptr=2), then 33 with grant_id=1 again.
- All requesting continuously, full=0, data 8'hA0+i:
  - grant_id sequence 0,0,1,1,2,2,0,0.
  - With max_burst=1: 0,1,2,0,1,2.
- Back-pressure: full=1, pop=0 with requester 2 valid.
  - push=0, req_ready=0, grant_id=2 held.
  - Raise pop=1 (allow=1): push=1, req_ready[2]=1 that cycle.
  - With allow=0: push stays 0 until full=0.
- Owner drops valid mid-burst: req0 accepted once (LOCKED), then req_valid[0]=0 while req1 is valid.
  - One cycle with grant_valid=0.
  - Next cycle grant_id=1.
- Reset mid-burst: rst pulsed asynchronously while LOCKED on owner 2.
  - push=0 immediately.
  - After release, with all valid: first grant_id=0.
- Random: 2000 cycles with random valid/data/full/pop, with a scoreboard pushing accepted (id,data).
  - Per-requester order is preserved.
  - No requester waits more than (n_req-1)*max_burst accepted transfers while continuously valid.
  - Never push when accept=0.

Source files
------------

// File: rtl/fifo_push_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among n_req producers.
// Optional burst locking lets one producer write up to max_burst consecutive words.
module fifo_push_rr_arbiter #(
  parameter int width = 8,
  parameter int n_req = 3,
  parameter int max_burst = 2,
  parameter bit allow_push_when_full_with_pop = 1'b1,
  localparam int id_w = (n_req > 1) ? $clog2(n_req) : 1,
  localparam int cnt_w = $clog2(max_burst + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_valid,
  input  logic [n_req*width-1:0]   req_data,
  output logic [n_req-1:0]         req_ready,
  output logic                     push,
  output logic [width-1:0]         write_data,
  input  logic                     full,
  input  logic                     pop,
  output logic                     grant_valid,
  output logic [id_w-1:0]          grant_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [id_w-1:0]  ptr_reg, ptr_next;
  logic [id_w-1:0]  owner_reg, owner_next;
  logic [cnt_w-1:0] cnt_reg, cnt_next;
  logic [width-1:0] data_arr [n_req];
  logic             accept;
  logic             rr_found;
  logic [id_w-1:0]  rr_id;

  for (genvar gi = 0; gi < n_req; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*width +: width];
  end

  function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] v);
    if (int'(v) >= n_req - 1) return '0;
    return v + id_w'(1);
  endfunction

  // A full FIFO can still take a word if it is being popped in the same cycle.
  assign accept = ~full | (allow_push_when_full_with_pop & full & pop);

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_id    = '0;
    for (int k = 0; k < n_req; k++) begin
      idx = (int'(ptr_reg) + k) % n_req;
      if (!rr_found && req_valid[idx]) begin
        rr_found = 1'b1;
        rr_id    = id_w'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    grant_valid = 1'b0;
    grant_id    = '0;
    req_ready   = '0;

    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          grant_valid = 1'b1;
          grant_id    = rr_id;
          if (accept) begin
            if (max_burst == 1) begin
              ptr_next = wrap_inc(rr_id);
            end else begin
              state_next = LOCKED;
              owner_next = rr_id;
              cnt_next   = cnt_w'(1);
            end
          end
        end
      end
      LOCKED: begin
        if (req_valid[owner_reg]) begin
          grant_valid = 1'b1;
          grant_id    = owner_reg;
          if (accept) begin
            cnt_next = cnt_reg + cnt_w'(1);
            if (int'(cnt_reg) + 1 >= max_burst) begin
              state_next = IDLE;
              ptr_next   = wrap_inc(owner_reg);
            end
          end
        end else begin
          // Owner went idle: give up the lock, costing one bubble cycle.
          state_next = IDLE;
          ptr_next   = wrap_inc(owner_reg);
        end
      end
      default: state_next = IDLE;
    endcase

    push = grant_valid & accept & ~rst;
    if (push) req_ready[grant_id] = 1'b1;
  end

  assign write_data = data_arr[grant_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_push_rr_arbiter.sv
// Directed and randomized checks of fifo_push_rr_arbiter: burst locking,
// pure round-robin, back-pressure with/without push-on-pop, reset and fairness.
module tb_fifo_push_rr_arbiter;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic full = 1'b0;
  logic pop  = 1'b0;

  logic [N-1:0]  req_ready, req_ready_rr, req_ready_na;
  logic          push, push_rr, push_na;
  logic [W-1:0]  write_data, write_data_rr, write_data_na;
  logic          grant_valid, grant_valid_rr, grant_valid_na;
  logic [IW-1:0] grant_id, grant_id_rr, grant_id_na;

  int n_vec = 0;
  int n_bad = 0;
  bit quiet = 1'b0;

  int exp_mb2 [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
  int exp_rr  [8] = '{0, 1, 2, 0, 1, 2, 0, 1};

  always #5 clk = ~clk;

  fifo_push_rr_arbiter #(.width(W), .n_req(N), .max_burst(2), .allow_push_when_full_with_pop(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .push(push), .write_data(write_data), .full(full), .pop(pop),
    .grant_valid(grant_valid), .grant_id(grant_id));

  fifo_push_rr_arbiter #(.width(W), .n_req(N), .max_burst(1), .allow_push_when_full_with_pop(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready_rr),
    .push(push_rr), .write_data(write_data_rr), .full(full), .pop(pop),
    .grant_valid(grant_valid_rr), .grant_id(grant_id_rr));

  fifo_push_rr_arbiter #(.width(W), .n_req(N), .max_burst(2), .allow_push_when_full_with_pop(1'b0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready_na),
    .push(push_na), .write_data(write_data_na), .full(full), .pop(pop),
    .grant_valid(grant_valid_na), .grant_id(grant_id_na));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end else if (!quiet) begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    full = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;
    #1;
    rst  = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    req_data = {d2, d1, d0};
  endtask

  initial begin
    logic [N-1:0] vld;
    int seq [N];
    int wt  [N];
    int worst;
    logic acc;

    // reset state: outputs held low while rst is high, then grant starts at 0
    req_valid = 3'b111;
    set_data(8'hA0, 8'hA1, 8'hA2);
    #2;
    check("rst_push", 32'(push), 0);
    check("rst_ready", 32'(req_ready), 0);
    next_cycle();
    rst = 1'b0;
    #2;
    check("post_rst_gid", 32'(grant_id), 0);
    check("post_rst_push", 32'(push), 1);
    next_cycle();

    // single requester with valid held: 11, 22 (burst ends), 33 still to req 1
    do_reset();
    req_valid = 3'b010;
    set_data(8'h00, 8'h11, 8'h00);
    #2;
    check("t1_push0", 32'(push), 1);
    check("t1_gid0", 32'(grant_id), 1);
    check("t1_wd0", 32'(write_data), 32'h11);
    check("t1_rdy0", 32'(req_ready), 32'b010);
    next_cycle();
    set_data(8'h00, 8'h22, 8'h00);
    #2;
    check("t1_push1", 32'(push), 1);
    check("t1_gid1", 32'(grant_id), 1);
    check("t1_wd1", 32'(write_data), 32'h22);
    next_cycle();
    set_data(8'h00, 8'h33, 8'h00);
    #2;
    check("t1_push2", 32'(push), 1);
    check("t1_gid2", 32'(grant_id), 1);
    check("t1_wd2", 32'(write_data), 32'h33);
    next_cycle();
    req_valid = 3'b000;
    #2;
    check("t1_idle_gv", 32'(grant_valid), 0);
    check("t1_idle_push", 32'(push), 0);
    next_cycle();

    // all requesting: burst pairs on dut, strict rotation on dut_rr
    do_reset();
    req_valid = 3'b111;
    set_data(8'hA0, 8'hA1, 8'hA2);
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("t2_gid%0d", k), 32'(grant_id), 32'(exp_mb2[k]));
      check($sformatf("t2_wd%0d", k), 32'(write_data), 32'(8'hA0 + exp_mb2[k]));
      check($sformatf("t2_rr_gid%0d", k), 32'(grant_id_rr), 32'(exp_rr[k]));
      next_cycle();
    end

    // back-pressure on requester 2
    do_reset();
    req_valid = 3'b100;
    set_data(8'h00, 8'h00, 8'hC2);
    full = 1'b1;
    pop  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      check($sformatf("t3_stall_push%0d", k), 32'(push), 0);
      check($sformatf("t3_stall_rdy%0d", k), 32'(req_ready), 0);
      check($sformatf("t3_stall_gv%0d", k), 32'(grant_valid), 1);
      check($sformatf("t3_stall_gid%0d", k), 32'(grant_id), 2);
      check($sformatf("t3_na_push%0d", k), 32'(push_na), 0);
      next_cycle();
    end
    pop = 1'b1;
    #2;
    check("t3_pop_push", 32'(push), 1);
    check("t3_pop_rdy", 32'(req_ready), 32'b100);
    check("t3_pop_wd", 32'(write_data), 32'hC2);
    check("t3_na_pop_push", 32'(push_na), 0);
    check("t3_na_pop_gid", 32'(grant_id_na), 2);
    next_cycle();
    full = 1'b0;
    pop  = 1'b0;
    #2;
    check("t3_na_free_push", 32'(push_na), 1);
    check("t3_na_free_rdy", 32'(req_ready_na), 32'b100);
    next_cycle();

    // owner drops valid mid-burst: one bubble, then requester 1
    do_reset();
    req_valid = 3'b001;
    set_data(8'hD0, 8'hD1, 8'h00);
    #2;
    check("t4_first_gid", 32'(grant_id), 0);
    check("t4_first_push", 32'(push), 1);
    next_cycle();
    req_valid = 3'b010;
    #2;
    check("t4_bubble_gv", 32'(grant_valid), 0);
    check("t4_bubble_push", 32'(push), 0);
    next_cycle();
    #2;
    check("t4_next_gid", 32'(grant_id), 1);
    check("t4_next_wd", 32'(write_data), 32'hD1);
    check("t4_next_push", 32'(push), 1);
    next_cycle();

    // asynchronous reset while locked on owner 2
    do_reset();
    req_valid = 3'b100;
    set_data(8'h00, 8'h00, 8'hE2);
    #2;
    check("t5_lock_gid", 32'(grant_id), 2);
    next_cycle();
    #1;
    check("t5_locked_push", 32'(push), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_push", 32'(push), 0);
    check("t5_rst_rdy", 32'(req_ready), 0);
    rst = 1'b0;
    req_valid = 3'b111;
    #1;
    check("t5_after_gid", 32'(grant_id), 0);
    check("t5_after_push", 32'(push), 1);
    next_cycle();

    // random traffic with a per-requester sequence scoreboard
    do_reset();
    quiet = 1'b1;
    vld = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      wt[i]  = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) vld[i] = ($urandom_range(0, 3) != 0);
        req_data[i*W +: W] = 8'((i << 6) | (seq[i] & 63));
      end
      req_valid = vld;
      full = ($urandom_range(0, 2) == 0);
      pop  = 1'($urandom_range(0, 1));
      #2;
      acc = !full || pop;
      check("rnd_no_push_without_accept", 32'(push & ~acc), 0);
      check("rnd_ready_onehot0", 32'($onehot0(req_ready)), 1);
      check("rnd_push_vs_ready", 32'(push), 32'(|req_ready));
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          check("rnd_order", 32'(write_data), 32'((i << 6) | (seq[i] & 63)));
          check("rnd_gid", 32'(grant_id), 32'(i));
        end
      end
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          vld[i] = 1'b0;
          seq[i]++;
          wt[i] = 0;
        end else if (vld[i] && push) begin
          wt[i]++;
        end
        if (wt[i] > worst) worst = wt[i];
      end
      check("rnd_fair_wait", 32'(worst <= (N - 1) * 2), 1);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
